tag_checkpoint_table: RTL

//  Stores register-tag snapshots for taggedRegs: one snapshot per in-flight branch, at most DEPTH.
//  On branch issue it captures all_tags_bus and returns a checkpoint index.
//  On mispredict it drives restore / restore_tags_bus / restore_index back into taggedRegs.
//  CDB broadcasts scrub live snapshots, so a restored tag never waits on an already-retired producer.

---
 rtl/tag_checkpoint_table.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tag_checkpoint_table.sv
// Branch checkpoint table: circular buffer of register-tag snapshots with CDB scrubbing
// and a one-cycle restore pulse back into taggedRegs on mispredict.
`timescale 1ns/1ps
`ifndef NUM_CDBBITS
`define NUM_CDBBITS 41
`endif
`ifndef CDB_ON_FIELD
`define CDB_ON_FIELD 40
`endif
`ifndef CDB_TAG_FIELD
`define CDB_TAG_FIELD 39:32
`endif

module tag_checkpoint_table #(
  parameter int TAG_W = 8,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc,
  input  logic [TAG_W*31-1:0]     alloc_tags_bus,
  output logic                    alloc_ack,
  output logic [IDX_W-1:0]        alloc_idx,
  output logic                    full,
  input  logic [`NUM_CDBBITS-1:0] cdb,
  input  logic                    resolve,
  input  logic [IDX_W-1:0]        resolve_idx,
  input  logic                    mispredict,
  input  logic [IDX_W-1:0]        mispredict_idx,
  output logic                    restore,
  output logic [TAG_W*31-1:0]     restore_tags_bus,
  output logic [IDX_W-1:0]        restore_index,
  output logic [IDX_W:0]          count
);

  localparam int NUM_REGS = 31;
  localparam int BUS_W    = TAG_W * NUM_REGS;

  logic [IDX_W:0]     head_r;
  logic [IDX_W:0]     tail_r;
  logic [DEPTH-1:0]   valid_r;
  logic [BUS_W-1:0]   snap_r [DEPTH];
  logic [BUS_W-1:0]   hold_r;
  logic               restore_r;
  logic [IDX_W-1:0]   restore_index_r;

  logic [TAG_W-1:0]   cdb_tag_s;
  logic               scrub_en_s;
  logic               cdb_unused_s;
  logic [IDX_W:0]     count_s;
  logic               full_s;
  logic [IDX_W-1:0]   head_idx_s;
  logic [IDX_W-1:0]   tail_idx_s;
  logic [IDX_W-1:0]   m_off_s;
  logic               alloc_fire_s;
  logic               res_fire_s;
  logic               mis_fire_s;
  logic               retire_s;
  logic [DEPTH-1:0]   valid_next_s;
  logic [IDX_W:0]     head_next_s;
  logic [IDX_W:0]     tail_next_s;

  function automatic logic [BUS_W-1:0] scrub(
    input logic [BUS_W-1:0] bus,
    input logic             en,
    input logic [TAG_W-1:0] tag
  );
    logic [BUS_W-1:0] res;
    res = bus;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (bus[i*TAG_W +: TAG_W] == tag)) begin
        res[i*TAG_W +: TAG_W] = {TAG_W{1'b0}};
      end else begin
        res[i*TAG_W +: TAG_W] = bus[i*TAG_W +: TAG_W];
      end
    end
    return res;
  endfunction

  assign cdb_unused_s = ^cdb;

  // Decode requests against the current occupancy and validity state.
  always_comb begin
    cdb_tag_s    = cdb[`CDB_TAG_FIELD];
    scrub_en_s   = cdb[`CDB_ON_FIELD] && (cdb_tag_s != {TAG_W{1'b0}});
    count_s      = tail_r - head_r;
    full_s       = (count_s == (IDX_W+1)'(DEPTH));
    head_idx_s   = head_r[IDX_W-1:0];
    tail_idx_s   = tail_r[IDX_W-1:0];
    m_off_s      = mispredict_idx - head_idx_s;
    mis_fire_s   = mispredict && valid_r[mispredict_idx];
    alloc_fire_s = alloc && !full_s && !mispredict;
    res_fire_s   = resolve && valid_r[resolve_idx] &&
                   !(mispredict && (mispredict_idx == resolve_idx));
    retire_s     = (count_s != {(IDX_W+1){1'b0}}) && !valid_r[head_idx_s];
  end

  // Next pointers and valid bits; a mispredict kills its entry and everything younger.
  always_comb begin
    valid_next_s = valid_r;
    valid_next_s[resolve_idx] = valid_r[resolve_idx] & ~res_fire_s;
    for (int k = 0; k < DEPTH; k++) begin
      valid_next_s[k] = valid_next_s[k] &
                        ~(mis_fire_s && ((IDX_W'(k) - head_idx_s) >= m_off_s));
    end
    valid_next_s[tail_idx_s] = valid_next_s[tail_idx_s] | alloc_fire_s;
    head_next_s = head_r + (IDX_W+1)'(retire_s);
    if (mis_fire_s) begin
      tail_next_s = head_r + (IDX_W+1)'(m_off_s);
    end else if (alloc_fire_s) begin
      tail_next_s = tail_r + (IDX_W+1)'(1);
    end else begin
      tail_next_s = tail_r;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r          <= {(IDX_W+1){1'b0}};
      tail_r          <= {(IDX_W+1){1'b0}};
      valid_r         <= {DEPTH{1'b0}};
      restore_r       <= 1'b0;
      restore_index_r <= {IDX_W{1'b0}};
    end else begin
      head_r    <= head_next_s;
      tail_r    <= tail_next_s;
      valid_r   <= valid_next_s;
      restore_r <= mis_fire_s;
      if (mis_fire_s) begin
        restore_index_r <= mispredict_idx;
      end
    end
  end

  // Snapshot storage and restore-hold copy; contents are don't-care until marked valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (alloc_fire_s && (tail_idx_s == IDX_W'(k))) begin
        snap_r[k] <= scrub(alloc_tags_bus, scrub_en_s, cdb_tag_s);
      end else begin
        snap_r[k] <= scrub(snap_r[k], scrub_en_s, cdb_tag_s);
      end
    end
    if (mis_fire_s) begin
      hold_r <= scrub(snap_r[mispredict_idx], scrub_en_s, cdb_tag_s);
    end
  end

  assign alloc_ack        = alloc_fire_s;
  assign alloc_idx        = tail_idx_s;
  assign full             = full_s;
  assign count            = count_s;
  assign restore          = restore_r;
  assign restore_index    = restore_index_r;
  assign restore_tags_bus = restore_r ? scrub(hold_r, scrub_en_s, cdb_tag_s) : {BUS_W{1'b0}};

endmodule
